fxp_divider_param: RTL and testbench
====================================

# fxp_divider_param

Parametrised, iterative fixed-point divider, the next generation of the team's fixed-width 10-bit divider. It computes Q_out = A_in / B_in for operands in a shared Q(W-F).F format, one quotient bit per clock, with truncation toward zero. It adds an optional two's-complement signed mode, and reports saturated results on divide-by-zero and overflow. It sits behind a start/busy/valid handshake and is controlled by an internal FSM with a single datapath; no external controller is needed.

## Interface
- W, 10: operand and quotient width in bits (W >= 4)
- F, 4: fractional bits of A_in, B_in and Q_out (0 <= F < W)
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and quotient

- clk  in  1  clock; all state updates on rising edge
- sclr  in  1  synchronous reset, active-high; overrides every other input
- start  in  1  request; sampled only when busy=0
- A_in  in  W  dividend, Q(W-F).F
- B_in  in  W  divisor, Q(W-F).F
- busy  out  1  high from the edge after acceptance until return to IDLE
- valid  out  1  one-cycle pulse; Q_out/dvz/ovf meaningful while high
- Q_out  out  W  quotient, Q(W-F).F, held until next result
- dvz  out  1  divide-by-zero flag, held with Q_out
- ovf  out  1  overflow/saturation flag, held with Q_out

## Operation
- Reset values: busy=0, valid=0, Q_out=0, dvz=0, ovf=0, FSM=IDLE, iteration counter=0.
- FSM states and transitions:
  - IDLE: on start, latch operands and go to CALC (or to FIX if B_in==0).
  - CALC: counter runs 0..W+F-1, then go to FIX.
  - FIX: go to DONE.
  - DONE: go to IDLE.
- Operand load (IDLE, start=1):
  - Signed mode: latch magnitudes |A|, |B| plus result sign sA^sB.
  - Unsigned mode: magnitude = raw operand, sign = 0.
  - Magnitudes are W bits; |-2^(W-1)| = 2^(W-1) is representable.
- CALC: restoring division of the W+F-bit dividend {|A|, F zeros} by |B|.
  - Each cycle, shift the (W+1)-bit partial remainder left and bring in the next dividend bit.
  - If remainder >= |B|, subtract |B| and shift in quotient bit 1; otherwise shift in 0.
  - The internal quotient register is W+F bits.
- FIX: build the result from internal quotient magnitude M.
  - Unsigned: if M > 2^W-1, set Q_out=2^W-1, ovf=1.
  - Signed, positive sign: if M > 2^(W-1)-1, set Q_out=2^(W-1)-1, ovf=1.
  - Signed, negative sign: if M > 2^(W-1), set Q_out=-2^(W-1), ovf=1; otherwise Q_out=-M.
  - In all other cases Q_out = M and ovf=0.
  - Register dvz=0 and set valid=1.
- Divide-by-zero: when B_in==0 at acceptance, CALC is skipped.
  - FIX sets dvz=1, ovf=0.
  - Unsigned: Q_out = 2^W-1.
  - Signed: Q_out = 2^(W-1)-1 if A_in >= 0, else -2^(W-1).
- DONE: valid returns to 0 and busy returns to 0 at the exit edge.
- Outputs Q_out/dvz/ovf hold their values until the next FIX.
- start while busy=1 (CALC, FIX or DONE) is ignored. Operand changes after acceptance have no effect.
- sclr mid-operation: the next edge returns all outputs to reset values, the in-flight result is discarded, and no valid pulse is produced.
- Zero dividend: Q_out=0, ovf=0, normal latency.

## Timing
- Edge E0 accepts start (IDLE, start=1). E0 also sets busy=1.
- Edges E1..E(W+F) perform the CALC iterations (14 with defaults).
- Edge E(W+F+1) is FIX: valid=1 and results appear in the following cycle.
- Edge E(W+F+2): valid=0, busy=0, FSM=IDLE. A new start can be accepted at E(W+F+3) at the earliest.
- Divide-by-zero path: FIX occurs at E1, valid is high in the cycle after E1, busy falls at E2.
- Throughput: one division per W+F+3 cycles.
- valid is never high for more than one cycle per accepted start.

## Test plan
- Unsigned, defaults: A=0x060 (6.0), B=0x020 (2.0), start pulse -> valid exactly 15 edges after acceptance; Q_out=0x030, dvz=0, ovf=0.
- Truncation: A=0x010 (1.0), B=0x030 (3.0) -> Q_out=0x005 (0.3125), ovf=0.
- Signed (SIGNED=1): A=0x3A0 (-6.0), B=0x020 (2.0) -> Q_out=0x3D0 (-3.0). Then A=0x200 (-32.0), B=0x3F0 (-1.0) -> Q_out=0x1FF, ovf=1.
- Overflow, unsigned: A=0x3FF, B=0x001 -> Q_out=0x3FF, ovf=1, dvz=0, normal latency.
- Divide-by-zero: B=0, A=0x060 -> valid in the cycle after E1, Q_out=0x3FF (unsigned), dvz=1. With SIGNED=1 and A=0x3A0 -> Q_out=0x200.
- Control corner cases:
  - start held high continuously -> one result per W+F+3 cycles.
  - start pulsed during CALC -> ignored.
  - sclr asserted at iteration 5 -> next cycle busy=0, Q_out=0, and valid never pulses for that operation.

Source files
------------

// File: rtl/fxp_divider_param.sv
// Iterative restoring fixed-point divider, Q(W-F).F operands and quotient, one quotient bit per clock.
// Optional two's-complement mode; divide-by-zero and overflow saturate the result and raise dvz/ovf.
module fxp_divider_param #(
  parameter int W      = 10,
  parameter int F      = 4,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         start,
  input  logic [W-1:0] A_in,
  input  logic [W-1:0] B_in,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] Q_out,
  output logic         dvz,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  // Handshake: start is sampled only while busy=0; an accepted start raises busy on the
  // same edge. valid is a one-cycle pulse and Q_out/dvz/ovf stay stable until the next result.

  localparam int QW = W + F;
  localparam int CW = $clog2(QW);

  localparam logic [QW:0]  LIM_U = {{(F+1){1'b0}}, {W{1'b1}}};
  localparam logic [QW:0]  LIM_P = {{(F+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic [QW:0]  LIM_N = {{(F+1){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_U = {W{1'b1}};
  localparam logic [W-1:0] MAX_P = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_N = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [QW-1:0] dvd;
  logic [W-1:0]  rem;
  logic [QW-1:0] quo;
  logic [W-1:0]  mag_b;
  logic          neg_q;
  logic          a_neg;
  logic          div_zero;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          a_sign;
  logic          b_sign;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;
  logic          ge;
  logic [QW:0]   m_ext;
  logic [W-1:0]  fix_q;
  logic          fix_ovf;

  assign dbg_state = state;

  always_comb begin
    a_sign = (SIGNED != 0) && A_in[W-1];
    b_sign = (SIGNED != 0) && B_in[W-1];
    // Magnitudes stay W bits wide: the most negative value maps to 2^(W-1) unsigned.
    a_mag  = a_sign ? -A_in : A_in;
    b_mag  = b_sign ? -B_in : B_in;
  end

  always_comb begin
    rem_sh  = {rem, dvd[QW-1]};
    ge      = rem_sh >= {1'b0, mag_b};
    rem_sub = rem_sh - {1'b0, mag_b};
  end

  always_comb begin
    m_ext   = {1'b0, quo};
    fix_q   = quo[W-1:0];
    fix_ovf = 1'b0;
    if (div_zero) begin
      if (SIGNED == 0) fix_q = MAX_U;
      else             fix_q = a_neg ? MIN_N : MAX_P;
    end else if (SIGNED == 0) begin
      if (m_ext > LIM_U) begin
        fix_q   = MAX_U;
        fix_ovf = 1'b1;
      end
    end else if (!neg_q) begin
      if (m_ext > LIM_P) begin
        fix_q   = MAX_P;
        fix_ovf = 1'b1;
      end
    end else begin
      if (m_ext > LIM_N) begin
        fix_q   = MIN_N;
        fix_ovf = 1'b1;
      end else begin
        fix_q   = -quo[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      rem      <= '0;
      quo      <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      a_neg    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      Q_out    <= '0;
      dvz      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            dvd      <= QW'(a_mag) << F;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            mag_b    <= b_mag;
            neg_q    <= a_sign ^ b_sign;
            a_neg    <= a_sign;
            div_zero <= (B_in == '0);
            state    <= (B_in == '0) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          rem <= ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
          quo <= {quo[QW-2:0], ge};
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(QW - 1)) state <= S_FIX;
        end
        S_FIX: begin
          Q_out <= fix_q;
          ovf   <= fix_ovf;
          dvz   <= div_zero;
          valid <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_divider_param.sv
// Directed bench for fxp_divider_param: an unsigned and a signed instance share clock and stimulus.
// Hand-computed expectations cover latency, truncation, saturation, divide-by-zero and control corners.
module tb_fxp_divider_param;

  logic       clk = 1'b0;
  logic       sclr = 1'b1;
  logic       start = 1'b0;
  logic [9:0] a_in = '0;
  logic [9:0] b_in = '0;

  logic       busy_u, valid_u, dvz_u, ovf_u;
  logic [9:0] q_u;
  logic [1:0] st_u;
  logic       busy_s, valid_s, dvz_s, ovf_s;
  logic [9:0] q_s;
  logic [1:0] st_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fxp_divider_param #(.W(10), .F(4), .SIGNED(0)) dut_u (
    .clk(clk), .sclr(sclr), .start(start), .A_in(a_in), .B_in(b_in),
    .busy(busy_u), .valid(valid_u), .Q_out(q_u), .dvz(dvz_u), .ovf(ovf_u),
    .dbg_state(st_u)
  );

  fxp_divider_param #(.W(10), .F(4), .SIGNED(1)) dut_s (
    .clk(clk), .sclr(sclr), .start(start), .A_in(a_in), .B_in(b_in),
    .busy(busy_s), .valid(valid_s), .Q_out(q_s), .dvz(dvz_s), .ovf(ovf_s),
    .dbg_state(st_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns after the acceptance edge E0 (+1 time unit).
  task automatic launch(input logic [9:0] a, input logic [9:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after E0 until the selected instance shows valid; -1 on timeout.
  task automatic wait_valid(input bit sel_s, input int already, output int lat);
    lat = -1;
    for (int n = already + 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (sel_s ? valid_s : valid_u) begin
        lat = n;
        break;
      end
    end
  endtask

  // After the valid cycle: pulse must drop and busy must fall at the next edge.
  task automatic finish_op(input string tag, input bit sel_s);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, sel_s ? valid_s : valid_u, 0);
    chk({tag, "_busy_drop"}, sel_s ? busy_s : busy_u, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int v1;
    int v2;
    int seen;

    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    chk("rst_busy", busy_u, 0);
    chk("rst_valid", valid_u, 0);
    chk("rst_q", q_u, 0);
    chk("rst_flags", {dvz_u, ovf_u}, 0);
    chk("rst_state", st_u, 0);
    chk("rst_q_s", q_s, 0);

    // 6.0 / 2.0 = 3.0
    launch(10'h060, 10'h020);
    chk("u_busy_e0", busy_u, 1);
    wait_valid(0, 0, lat);
    chk("u_lat", lat, 15);
    chk("u_q", q_u, 10'h030);
    chk("u_flags", {dvz_u, ovf_u}, 0);
    chk("u_busy_valid", busy_u, 1);
    finish_op("u", 0);

    // 1.0 / 3.0 truncates to 0.3125
    launch(10'h010, 10'h030);
    wait_valid(0, 0, lat);
    chk("trunc_lat", lat, 15);
    chk("trunc_q", q_u, 10'h005);
    chk("trunc_ovf", ovf_u, 0);
    finish_op("trunc", 0);

    // Unsigned overflow
    launch(10'h3FF, 10'h001);
    wait_valid(0, 0, lat);
    chk("uovf_lat", lat, 15);
    chk("uovf_q", q_u, 10'h3FF);
    chk("uovf_flags", {dvz_u, ovf_u}, 2'b01);
    finish_op("uovf", 0);

    // Zero dividend
    launch(10'h000, 10'h020);
    wait_valid(0, 0, lat);
    chk("zero_lat", lat, 15);
    chk("zero_q", q_u, 0);
    chk("zero_flags", {dvz_u, ovf_u}, 0);
    finish_op("zero", 0);

    // Signed: -6.0 / 2.0 = -3.0
    launch(10'h3A0, 10'h020);
    wait_valid(1, 0, lat);
    chk("s_lat", lat, 15);
    chk("s_q", q_s, 10'h3D0);
    chk("s_flags", {dvz_s, ovf_s}, 0);
    finish_op("s", 1);

    // Signed: -32.0 / -1.0 saturates positive
    launch(10'h200, 10'h3F0);
    wait_valid(1, 0, lat);
    chk("sovf_q", q_s, 10'h1FF);
    chk("sovf_flags", {dvz_s, ovf_s}, 2'b01);
    finish_op("sovf", 1);

    // Signed: -32.0 / 1.0 = -32.0 exactly representable
    launch(10'h200, 10'h010);
    wait_valid(1, 0, lat);
    chk("smin_q", q_s, 10'h200);
    chk("smin_ovf", ovf_s, 0);
    finish_op("smin", 1);

    // Signed: 6.0 / -2.0 = -3.0
    launch(10'h060, 10'h3E0);
    wait_valid(1, 0, lat);
    chk("smix_q", q_s, 10'h3D0);
    finish_op("smix", 1);

    // Divide by zero, positive dividend
    launch(10'h060, 10'h000);
    wait_valid(0, 0, lat);
    chk("dvz_lat", lat, 1);
    chk("dvz_q_u", q_u, 10'h3FF);
    chk("dvz_flags_u", {dvz_u, ovf_u}, 2'b10);
    chk("dvz_q_s_pos", q_s, 10'h1FF);
    finish_op("dvz", 0);

    // Divide by zero, negative dividend in signed mode
    launch(10'h3A0, 10'h000);
    wait_valid(1, 0, lat);
    chk("dvzs_lat", lat, 1);
    chk("dvzs_q", q_s, 10'h200);
    chk("dvzs_flags", {dvz_s, ovf_s}, 2'b10);
    finish_op("dvzs", 1);

    // Operand changes after acceptance have no effect
    launch(10'h060, 10'h020);
    a_in = 10'h3FF;
    b_in = 10'h000;
    wait_valid(0, 0, lat);
    chk("hold_lat", lat, 15);
    chk("hold_q", q_u, 10'h030);
    finish_op("hold", 0);

    // start pulsed during CALC is ignored
    launch(10'h060, 10'h020);
    repeat (3) @(posedge clk);
    #1;
    a_in  = 10'h3FF;
    b_in  = 10'h001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid(0, 4, lat);
    chk("ign_lat", lat, 15);
    chk("ign_q", q_u, 10'h030);
    chk("ign_ovf", ovf_u, 0);
    finish_op("ign", 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_no_second", busy_u, 0);

    // start held high: one result every 17 cycles
    a_in  = 10'h060;
    b_in  = 10'h020;
    start = 1'b1;
    v1 = -1;
    v2 = -1;
    for (int n = 0; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (valid_u) begin
        if (v1 < 0) v1 = n;
        else begin
          v2 = n;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("held_first", v1, 15);
    chk("held_period", v2 - v1, 17);
    chk("held_q", q_u, 10'h030);
    repeat (3) @(posedge clk);
    #1;
    chk("held_idle", busy_u, 0);

    // Prime Q_out with a nonzero value, then reset in the middle of an operation
    launch(10'h3FF, 10'h001);
    wait_valid(0, 0, lat);
    finish_op("prime", 0);
    chk("prime_q", q_u, 10'h3FF);
    launch(10'h060, 10'h020);
    repeat (5) @(posedge clk);
    #1 sclr = 1'b1;
    @(posedge clk);
    #1;
    chk("sclr_busy", busy_u, 0);
    chk("sclr_q", q_u, 0);
    chk("sclr_flags", {valid_u, dvz_u, ovf_u}, 0);
    chk("sclr_state", st_u, 0);
    sclr = 1'b0;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (valid_u || busy_u) seen++;
    end
    chk("sclr_no_valid", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
